klein_decipher: RTL and testbench

KLEIN-64 decryption engine, the inverse of the KLEIN cipher core. It accepts a 64-bit ciphertext and the 64-bit cipher key, and returns the 64-bit plaintext. The block first derives the final round key by running the forward key schedule, then executes 12 inverse rounds while un-scheduling the key. It sits beside the cipher core behind the same Avalon-style register wrapper and reuses klein_sbox (an involution) and klein_mixcolumn with iinv=1.

---
 rtl/klein_pkg.sv | 78 +++++++
 rtl/klein_decipher_if.sv | 22 ++
 rtl/klein_key_unschedule.sv | 29 ++
 rtl/klein_mixcolumn.sv | 12 +
 rtl/klein_sbox.sv | 26 ++
 rtl/klein_decipher.sv | 168 ++++++++++++++++
 tb/tb_klein_decipher.sv | 243 ++++++++++++++++++++++++
 7 files changed

// File: rtl/klein_pkg.sv
// Shared KLEIN-64 types, round constants and byte/nibble helpers.
// Used by the cipher and decipher cores alike.
package klein_pkg;

  localparam int KLEIN_ROUNDS = 12;

  typedef logic [3:0]  round_t;
  typedef logic [0:63] blk_t;

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    DEC
  } fsm_e;

  function automatic logic [0:31] rotl8(
    input logic [0:31] w
  );
    return {w[8:31], w[0:7]};
  endfunction

  function automatic logic [0:31] rotr8(
    input logic [0:31] w
  );
    return {w[24:31], w[0:23]};
  endfunction

  function automatic blk_t rotl16(input blk_t s);
    return {s[16:63], s[0:15]};
  endfunction

  function automatic blk_t rotr16(input blk_t s);
    return {s[48:63], s[0:47]};
  endfunction

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant
  function automatic logic [7:0] gmul(
    input logic [7:0] b,
    input logic [3:0] c
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? b  : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^
           (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [0:31] mix_col(
    input logic [0:31] w,
    input bit          inv
  );
    logic [7:0]  b [4];
    logic [3:0]  c [4];
    logic [0:31] r;
    for (int k = 0; k < 4; k++)
      b[k] = w[8*k +: 8];
    c[0] = inv ? 4'd14 : 4'd2;
    c[1] = inv ? 4'd11 : 4'd3;
    c[2] = inv ? 4'd13 : 4'd1;
    c[3] = inv ? 4'd9  : 4'd1;
    for (int j = 0; j < 4; j++)
      r[8*j +: 8] = gmul(b[j], c[0]) ^
                    gmul(b[(j+1)%4], c[1]) ^
                    gmul(b[(j+2)%4], c[2]) ^
                    gmul(b[(j+3)%4], c[3]);
    return r;
  endfunction

endpackage

// File: rtl/klein_decipher_if.sv
// Request/response bundle of the KLEIN-64 decipher engine.
// master drives the request, slave returns the plaintext.
interface klein_decipher_if;
  import klein_pkg::*;

  logic istart;
  blk_t iblock;
  blk_t ikey;
  logic oready;
  logic obusy;
  blk_t oblock;

  modport master (
    output istart, iblock, ikey,
    input  oready, obusy, oblock
  );

  modport slave (
    input  istart, iblock, ikey,
    output oready, obusy, oblock
  );
endinterface

// File: rtl/klein_key_unschedule.sv
// Combinational inverse key schedule: K(r+1) -> K(r).
module klein_key_unschedule
  import klein_pkg::*;
(
  input  blk_t   key,
  input  round_t rc,
  output blk_t   prev
);
  logic [0:15] sb;
  blk_t        t;
  logic [0:31] l, r;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sb
    klein_sbox u_sb (
      .x (key[40 + 4*g +: 4]),
      .y (sb[4*g +: 4])
    );
  end

  always_comb begin
    t         = key;
    t[40:55]  = sb;
    t[16:23]  = t[16:23] ^ {4'h0, rc};
    l         = t[32:63] ^ t[0:31];
    r         = t[0:31];
    prev      = {rotr8(l), rotr8(r)};
  end
endmodule

// File: rtl/klein_mixcolumn.sv
// AES-style column mix on one 32-bit half of the state.
// iinv=1 selects the inverse matrix.
module klein_mixcolumn
  import klein_pkg::*;
#(
  parameter bit iinv = 1'b0
) (
  input  logic [0:31] x,
  output logic [0:31] y
);
  assign y = mix_col(x, iinv);
endmodule

// File: rtl/klein_sbox.sv
// KLEIN 4-bit S-box; an involution, so it serves both directions.
module klein_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  always_comb begin
    unique case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'ha;
      4'h3: y = 4'h9;
      4'h4: y = 4'h1;
      4'h5: y = 4'hf;
      4'h6: y = 4'hb;
      4'h7: y = 4'h0;
      4'h8: y = 4'hc;
      4'h9: y = 4'h3;
      4'ha: y = 4'h2;
      4'hb: y = 4'h6;
      4'hc: y = 4'h8;
      4'hd: y = 4'he;
      4'he: y = 4'hd;
      4'hf: y = 4'h5;
    endcase
  end
endmodule

// File: rtl/klein_decipher.sv
// KLEIN-64 decryption engine: forward key expansion, then 12 inverse rounds.
// Define KLEIN_DECIPHER_KEY_CACHE_EN to skip key expansion on a repeated key.
module klein_decipher
  import klein_pkg::*;
(
  input logic             iclk,
  input logic             ireset,
  klein_decipher_if.slave bus
);
  localparam round_t LAST = round_t'(KLEIN_ROUNDS - 1);

  fsm_e   fsm, fsm_n;
  blk_t   st, st_n;
  blk_t   kst, kst_n;
  blk_t   oblk, oblk_n;
  round_t rnd, rnd_n, rc;
  logic   ready, ready_n;
  logic   hit;
  blk_t   cached_k12;

  logic [0:31] ka, kb, fa, fb;
  logic [0:15] ks_sb;
  blk_t        ks_next;

  assign rc = rnd + 4'd1;
  assign ka = rotl8(kst[0:31]);
  assign kb = rotl8(kst[32:63]);
  assign fa = kb ^ {20'h0, rc, 8'h0};
  assign fb = ka ^ kb;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_ks_sb
    klein_sbox u_sb (
      .x (fb[8 + 4*g +: 4]),
      .y (ks_sb[4*g +: 4])
    );
  end

  assign ks_next = {fa, fb[0:7], ks_sb, fb[24:31]};

  blk_t kr, mixed, rot, sub, dec_next;

  klein_key_unschedule u_kus (
    .key  (kst),
    .rc   (rc),
    .prev (kr)
  );

  klein_mixcolumn #(.iinv(1'b1)) u_mix0 (
    .x (st[0:31]),
    .y (mixed[0:31])
  );

  klein_mixcolumn #(.iinv(1'b1)) u_mix1 (
    .x (st[32:63]),
    .y (mixed[32:63])
  );

  assign rot = rotr16(mixed);

  for (g = 0; g < 16; g++) begin : g_dp_sb
    klein_sbox u_sb (
      .x (rot[4*g +: 4]),
      .y (sub[4*g +: 4])
    );
  end

  assign dec_next = sub ^ kr;

`ifdef KLEIN_DECIPHER_KEY_CACHE_EN
  blk_t last_key;
  logic c_valid;

  // key is captured at accept; K12 only becomes valid once expansion ends
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      last_key   <= '0;
      cached_k12 <= '0;
      c_valid    <= 1'b0;
    end else begin
      if (fsm == IDLE && bus.istart && !hit) begin
        last_key <= bus.ikey;
        c_valid  <= 1'b0;
      end
      if (fsm == KEYEXP && rnd == LAST) begin
        cached_k12 <= ks_next;
        c_valid    <= 1'b1;
      end
    end
  end

  assign hit = c_valid && (bus.ikey == last_key);
`else
  assign hit        = 1'b0;
  assign cached_k12 = '0;
`endif

  always_comb begin
    fsm_n   = fsm;
    st_n    = st;
    kst_n   = kst;
    rnd_n   = rnd;
    ready_n = ready;
    oblk_n  = oblk;
    unique case (fsm)
      IDLE: begin
        if (bus.istart) begin
          ready_n = 1'b0;
          oblk_n  = '0;
          if (hit) begin
            kst_n = cached_k12;
            st_n  = bus.iblock ^ cached_k12;
            rnd_n = LAST;
            fsm_n = DEC;
          end else begin
            kst_n = bus.ikey;
            st_n  = bus.iblock;
            rnd_n = '0;
            fsm_n = KEYEXP;
          end
        end
      end
      KEYEXP: begin
        kst_n = ks_next;
        rnd_n = rnd + 4'd1;
        if (rnd == LAST) begin
          st_n  = st ^ ks_next;
          rnd_n = LAST;
          fsm_n = DEC;
        end
      end
      DEC: begin
        st_n  = dec_next;
        kst_n = kr;
        rnd_n = rnd - 4'd1;
        if (rnd == '0) begin
          rnd_n   = '0;
          oblk_n  = dec_next;
          ready_n = 1'b1;
          fsm_n   = IDLE;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      fsm   <= IDLE;
      st    <= '0;
      kst   <= '0;
      rnd   <= '0;
      ready <= 1'b0;
      oblk  <= '0;
    end else begin
      fsm   <= fsm_n;
      st    <= st_n;
      kst   <= kst_n;
      rnd   <= rnd_n;
      ready <= ready_n;
      oblk  <= oblk_n;
    end
  end

  assign bus.oready = ready;
  assign bus.obusy  = (fsm != IDLE);
  assign bus.oblock = oblk;
endmodule

// File: tb/tb_klein_decipher.sv
// Scoreboard bench for klein_decipher with a byte-level KLEIN-64 model.
// Covers known vectors, back-to-back, ignored start, reset, random round-trips.
module tb_klein_decipher;

`ifdef KLEIN_DECIPHER_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic iclk = 1'b0;
  logic ireset = 1'b1;

  klein_decipher_if dif ();

  klein_decipher dut (
    .iclk   (iclk),
    .ireset (ireset),
    .bus    (dif)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [63:0] pt;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mvalid = 1'b0;
  logic [63:0] mkey = '0;
  bit          prev_rdy = 1'b0;

  always @(posedge iclk) cyc = cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] sb(input logic [3:0] n);
    case (n)
      4'h0: return 4'h7;  4'h1: return 4'h4;
      4'h2: return 4'ha;  4'h3: return 4'h9;
      4'h4: return 4'h1;  4'h5: return 4'hf;
      4'h6: return 4'hb;  4'h7: return 4'h0;
      4'h8: return 4'hc;  4'h9: return 4'h3;
      4'ha: return 4'h2;  4'hb: return 4'h6;
      4'hc: return 4'h8;  4'hd: return 4'he;
      4'he: return 4'hd;  default: return 4'h5;
    endcase
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [63:0] subn(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(s[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] mixc(input logic [63:0] s);
    logic [63:0] r;
    logic [7:0]  a [4];
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[63 - 32*c - 8*j -: 8];
      r[63 - 32*c      -: 8] = m2(a[0]) ^ m2(a[1]) ^ a[1] ^ a[2] ^ a[3];
      r[63 - 32*c - 8  -: 8] = a[0] ^ m2(a[1]) ^ m2(a[2]) ^ a[2] ^ a[3];
      r[63 - 32*c - 16 -: 8] = a[0] ^ a[1] ^ m2(a[2]) ^ m2(a[3]) ^ a[3];
      r[63 - 32*c - 24 -: 8] = m2(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ m2(a[3]);
    end
    return r;
  endfunction

  function automatic logic [63:0] ks(input logic [63:0] k, input int i);
    logic [7:0]  b [8];
    logic [7:0]  n [8];
    logic [63:0] r;
    for (int j = 0; j < 8; j++) b[j] = k[63 - 8*j -: 8];
    for (int j = 0; j < 4; j++) begin
      n[j]     = b[4 + (j+1)%4];
      n[4 + j] = b[(j+1)%4] ^ b[4 + (j+1)%4];
    end
    n[2] = n[2] ^ 8'(i);
    n[5] = {sb(n[5][7:4]), sb(n[5][3:0])};
    n[6] = {sb(n[6][7:4]), sb(n[6][3:0])};
    for (int j = 0; j < 8; j++) r[63 - 8*j -: 8] = n[j];
    return r;
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] key,
                                          input logic [63:0] pt);
    logic [63:0] s, sk;
    s  = pt;
    sk = key;
    for (int i = 1; i <= 12; i++) begin
      s  = s ^ sk;
      s  = subn(s);
      s  = {s[47:0], s[63:48]};
      s  = mixc(s);
      sk = ks(sk, i);
    end
    return s ^ sk;
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(input logic [63:0] key,
                       input logic [63:0] ct,
                       input logic [63:0] pt,
                       input int          pulse_at);
    int lat;
    bit done;
    lat = (CACHE_ON && mvalid && key == mkey) ? 12 : 24;
    mkey   = key;
    mvalid = 1'b1;
    dif.istart = 1'b1;
    dif.ikey   = key;
    dif.iblock = ct;
    sb_q.push_back('{pt, lat, cyc + 1});
    @(negedge iclk);
    dif.istart = 1'b0;
    dif.ikey   = {$urandom, $urandom};
    dif.iblock = {$urandom, $urandom};
    chk("busy_after_start", 64'(dif.obusy), 64'd1);
    chk("ready_cleared", 64'(dif.oready), 64'd0);
    chk("oblock_cleared", dif.oblock, 64'd0);
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (dif.oready) begin
        done = 1'b1;
      end else begin
        dif.istart = (c == pulse_at);
        @(negedge iclk);
      end
    end
    dif.istart = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=no_oready required=oready_within_40");
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge iclk) begin
    exp_t e;
    if (dif.oready && !prev_rdy) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h required=none",
                 dif.oblock);
      end else begin
        e = sb_q.pop_front();
        chk("plaintext", dif.oblock, e.pt);
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
        chk("busy_drop", 64'(dif.obusy), 64'd0);
      end
    end
    prev_rdy = dif.oready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] key, pt, ct, pkey;
    dif.istart = 1'b0;
    dif.iblock = '0;
    dif.ikey   = '0;
    repeat (3) @(negedge iclk);
    ireset = 1'b0;
    @(negedge iclk);
    chk("reset_oready", 64'(dif.oready), 64'd0);
    chk("reset_obusy", 64'(dif.obusy), 64'd0);
    chk("reset_oblock", dif.oblock, 64'd0);

    issue(64'h0, 64'hCDC0B51F14722BBE, 64'hFFFFFFFFFFFFFFFF, 0);
    issue(64'hFFFFFFFFFFFFFFFF, 64'h6456764E8602E154, 64'h0, 0);
    issue(64'h1234567890ABCDEF, 64'h592356C4997176C8,
          64'hFFFFFFFFFFFFFFFF, 0);

    // back-to-back with a repeated key
    issue(64'h0, 64'hCDC0B51F14722BBE, 64'hFFFFFFFFFFFFFFFF, 0);
    issue(64'h0, 64'h629F9D6DFF95800E, 64'h1234567890ABCDEF, 0);

    // start pulse during DEC must be ignored
    issue(64'h1234567890ABCDEF, 64'h592356C4997176C8,
          64'hFFFFFFFFFFFFFFFF, 16);
    chk("busy_idle_after_pulse", 64'(dif.obusy), 64'd0);

    // reset in the middle of a decryption
    dif.istart = 1'b1;
    dif.ikey   = 64'h0;
    dif.iblock = 64'hCDC0B51F14722BBE;
    @(negedge iclk);
    dif.istart = 1'b0;
    repeat (14) @(negedge iclk);
    chk("busy_before_reset", 64'(dif.obusy), 64'd1);
    ireset = 1'b1;
    #1;
    chk("midreset_oready", 64'(dif.oready), 64'd0);
    chk("midreset_obusy", 64'(dif.obusy), 64'd0);
    chk("midreset_oblock", dif.oblock, 64'd0);
    sb_q.delete();
    mvalid = 1'b0;
    @(negedge iclk);
    ireset = 1'b0;
    @(negedge iclk);
    issue(64'h0, 64'hCDC0B51F14722BBE, 64'hFFFFFFFFFFFFFFFF, 0);

    // random round-trips, with occasional key reuse
    pkey = 64'h0;
    for (int n = 0; n < 300; n++) begin
      key = (n % 4 == 3) ? pkey : {$urandom, $urandom};
      pt  = {$urandom, $urandom};
      ct  = encrypt(key, pt);
      issue(key, ct, pt, 0);
      pkey = key;
    end

    @(negedge iclk);
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
